// File: rtl/multu_seq.sv
// Sequential shift-add multiplier producing a 2*WIDTH-bit product into HI/LO.
// Fixed latency with a start/busy/done handshake, signed (MULT) or unsigned (MULTU).
module multu_seq #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             multurst_n,
   input  logic             multustart,
   input  logic             multusgn,
   input  logic [WIDTH-1:0] multua,
   input  logic [WIDTH-1:0] multub,
   output logic             multubusy,
   output logic             multudone,
   output logic [WIDTH-1:0] multuhi,
   output logic [WIDTH-1:0] multulo
);

   localparam int unsigned PW = 2 * WIDTH;
   localparam int unsigned CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_t;

   state_t           state_q, state_d;
   logic [PW-1:0]    acc_q, acc_d;
   logic [PW-1:0]    mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [CW-1:0]    count_q, count_d;
   logic             neg_q, neg_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;

   logic [WIDTH-1:0] abs_a;
   logic [WIDTH-1:0] abs_b;
   logic [PW-1:0]    prod;

   // Magnitude of the most negative value (2^(WIDTH-1)) is representable as unsigned.
   always_comb begin
      abs_a = multua;
      abs_b = multub;
      if (multusgn && multua[WIDTH-1]) begin
         abs_a = ~multua + WIDTH'(1);
      end
      if (multusgn && multub[WIDTH-1]) begin
         abs_b = ~multub + WIDTH'(1);
      end
   end

   always_comb begin
      prod = acc_q;
      if (neg_q) begin
         prod = ~acc_q + PW'(1);
      end
   end

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      count_d  = count_q;
      neg_d    = neg_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      unique case (state_q)
         StIdle: begin
            if (multustart) begin
               mcand_d  = {{WIDTH{1'b0}}, abs_a};
               mplier_d = abs_b;
               neg_d    = multusgn & (multua[WIDTH-1] ^ multub[WIDTH-1]);
               acc_d    = '0;
               count_d  = '0;
               state_d  = StRun;
            end
         end
         StRun: begin
            // The shifting multiplicand stands in for (multiplicand << count).
            if (mplier_q[0]) begin
               acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            count_d  = count_q + CW'(1);
            if (count_q == LAST) begin
               state_d = StFix;
            end
         end
         StFix: begin
            hi_d    = prod[PW-1:WIDTH];
            lo_d    = prod[WIDTH-1:0];
            state_d = StDone;
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge multurst_n) begin
      if (!multurst_n) begin
         state_q  <= StIdle;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         count_q  <= '0;
         neg_q    <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         count_q  <= count_d;
         neg_q    <= neg_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
      end
   end

   assign multubusy = (state_q != StIdle);
   assign multudone = (state_q == StDone);
   assign multuhi   = hi_q;
   assign multulo   = lo_q;

endmodule

// File: tb/tb_multu_seq.sv
// Randomized self-checking bench for multu_seq against an arithmetic product model.
// Covers latency, busy window, ignored starts, output hold, mid-operation reset.
module tb_multu_seq;

   logic        clk;
   logic        multurst_n;
   logic        multustart;
   logic        multusgn;
   logic [31:0] multua;
   logic [31:0] multub;
   logic        multubusy;
   logic        multudone;
   logic [31:0] multuhi;
   logic [31:0] multulo;

   int n_checks;
   int n_pass;
   logic [63:0] prev_prod;

   multu_seq #(.WIDTH(32)) dut (
      .clk        (clk),
      .multurst_n (multurst_n),
      .multustart (multustart),
      .multusgn   (multusgn),
      .multua     (multua),
      .multub     (multub),
      .multubusy  (multubusy),
      .multudone  (multudone),
      .multuhi    (multuhi),
      .multulo    (multulo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] model(input bit sgn, input logic [31:0] a,
                                         input logic [31:0] b);
      longint      sa;
      longint      sb;
      logic [63:0] ua;
      logic [63:0] ub;
      if (sgn) begin
         sa = $signed(a);
         sb = $signed(b);
         return 64'(sa * sb);
      end
      ua = {32'h0, a};
      ub = {32'h0, b};
      return ua * ub;
   endfunction

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   // Called at a negedge in an IDLE cycle; returns at the negedge of the first IDLE cycle
   // after done. Extra start pulses are injected at cycles p1/p2 (0 = none).
   task automatic run_op(input string tag, input bit sgn, input logic [31:0] a,
                         input logic [31:0] b, input int p1, input int p2);
      logic [63:0] exp;
      int done_cyc;
      int n_done;
      int busy_bad;
      multustart = 1'b1;
      multusgn   = sgn;
      multua     = a;
      multub     = b;
      @(posedge clk);
      exp      = model(sgn, a, b);
      done_cyc = 0;
      n_done   = 0;
      busy_bad = 0;
      for (int k = 1; k <= 35; k++) begin
         @(negedge clk);
         if (k == p1 || k == p2) begin
            multustart = 1'b1;
            multusgn   = 1'b0;
            multua     = 32'd2;
            multub     = 32'd2;
         end else begin
            multustart = 1'b0;
            multusgn   = 1'($urandom_range(0, 1));
            multua     = $urandom;
            multub     = $urandom;
         end
         if (multudone) begin
            n_done++;
            if (done_cyc == 0) done_cyc = k;
         end
         if (k <= 34 && !multubusy) busy_bad++;
         if (k == 33) check_eq({tag, "_held"}, {multuhi, multulo}, prev_prod);
         if (k == 34) check_eq({tag, "_prod"}, {multuhi, multulo}, exp);
         if (k == 35) check_eq({tag, "_idle"}, 64'({multubusy, multudone}), 64'h0);
      end
      check_eq({tag, "_done_cycle"}, 64'(done_cyc), 64'd34);
      check_eq({tag, "_done_count"}, 64'(n_done), 64'd1);
      check_eq({tag, "_busy_gaps"}, 64'(busy_bad), 64'd0);
      prev_prod = exp;
   endtask

   initial begin
      int n_done;
      int n_busy;
      logic [31:0] ra;
      logic [31:0] rb;
      bit rs;
      n_checks   = 0;
      n_pass     = 0;
      prev_prod  = 64'h0;
      multurst_n = 1'b0;
      multustart = 1'b0;
      multusgn   = 1'b0;
      multua     = 32'h0;
      multub     = 32'h0;
      repeat (3) @(negedge clk);
      multurst_n = 1'b1;
      @(negedge clk);
      check_eq("reset_state", {28'h0, multubusy, multudone, 2'b00, multuhi, multulo}, 64'h0);

      run_op("umax", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
      check_eq("umax_const", prev_prod, 64'hFFFF_FFFE_0000_0001);
      run_op("smix", 1'b1, 32'hFFFF_FFFD, 32'd5, 0, 0);
      check_eq("smix_const", prev_prod, 64'hFFFF_FFFF_FFFF_FFF1);
      run_op("umix", 1'b0, 32'hFFFF_FFFD, 32'd5, 0, 0);
      run_op("smin2", 1'b1, 32'h8000_0000, 32'h8000_0000, 0, 0);
      check_eq("smin2_const", prev_prod, 64'h4000_0000_0000_0000);
      run_op("sneg1", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
      run_op("ignore", 1'b0, 32'd7, 32'd6, 5, 34);

      // Reset mid-operation: everything clears at once and no done follows.
      multustart = 1'b1;
      multusgn   = 1'b0;
      multua     = 32'h1234_5678;
      multub     = 32'h0000_0100;
      @(posedge clk);
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         multustart = 1'b0;
      end
      multurst_n = 1'b0;
      #1;
      check_eq("rst_outputs", {28'h0, multubusy, multudone, 2'b00, multuhi, multulo}, 64'h0);
      prev_prod = 64'h0;
      repeat (2) @(negedge clk);
      multurst_n = 1'b1;
      n_done = 0;
      n_busy = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (multudone) n_done++;
         if (multubusy) n_busy++;
      end
      check_eq("rst_no_done", 64'(n_done), 64'd0);
      check_eq("rst_no_busy", 64'(n_busy), 64'd0);
      run_op("post_rst", 1'b0, 32'h1234_5678, 32'h0000_0100, 0, 0);
      check_eq("post_rst_const", prev_prod, 64'h0000_0012_3456_7800);

      // Zero operand followed by back-to-back operations started in the first IDLE cycle.
      run_op("zero", 1'b0, 32'h0, 32'hDEAD_BEEF, 0, 0);
      for (int i = 0; i < 20; i++) begin
         rs = 1'($urandom_range(0, 1));
         ra = pick_operand();
         rb = pick_operand();
         run_op($sformatf("rand%0d", i), rs, ra, rb, 0, 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
